// File: rtl/lsu.sv
// Load-store unit for the single-cycle RV32I core.
// Holds the data memory and the memory-mapped I/O registers, performs
// byte-lane stores and sign/zero-extended combinational loads.
// Optional feature macro: LSU_MISALIGN_CHK_EN (misaligned access detection).
// Without it, half/word accesses are silently forced to natural alignment.
module lsu #(
    parameter int DMEM_AW     = 13,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    input  logic        wr_en,
    input  logic [3:0]  bmask,
    input  logic [2:0]  ld_sel,
    output logic [31:0] ld_data,
    output logic        misalign,
    input  logic [31:0] io_sw,
    input  logic [3:0]  io_btn,
    output logic [31:0] io_ledr,
    output logic [31:0] io_ledg,
    output logic [55:0] io_hex,
    output logic [31:0] io_lcd
);

    localparam int DMEM_WORDS = 2 ** (DMEM_AW - 2);

    // Word addresses (byte address >> 2) of the I/O registers
    localparam logic [29:0] WA_LEDR   = 30'h0400_0000;
    localparam logic [29:0] WA_LEDG   = 30'h0400_0400;
    localparam logic [29:0] WA_HEX_LO = 30'h0400_0800;
    localparam logic [29:0] WA_HEX_HI = 30'h0400_0C00;
    localparam logic [29:0] WA_LCD    = 30'h0400_1000;
    localparam logic [29:0] WA_SW     = 30'h0400_4000;
    localparam logic [29:0] WA_BTN    = 30'h0400_4400;

    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] ledr, ledg, hex_lo, hex_hi, lcd;
    logic [31:0] sw_sync  [SYNC_STAGES];
    logic [3:0]  btn_sync [SYNC_STAGES];

    logic [DMEM_AW-3:0] widx;
    logic sel_dmem, sel_ledr, sel_ledg, sel_hex_lo, sel_hex_hi, sel_lcd, sel_sw, sel_btn;
    logic st_word, st_half, ld_word, ld_half, ld_valid;
    logic [1:0]  st_off, ld_off;
    logic        mis;
    logic        do_store;
    logic [3:0]  st_lanes;
    logic [31:0] st_wdata;
    logic [31:0] rword, rshift;
    logic        mapped;

    assign widx       = addr[DMEM_AW-1:2];
    assign sel_dmem   = (addr[31:DMEM_AW] == '0);
    assign sel_ledr   = (addr[31:2] == WA_LEDR);
    assign sel_ledg   = (addr[31:2] == WA_LEDG);
    assign sel_hex_lo = (addr[31:2] == WA_HEX_LO);
    assign sel_hex_hi = (addr[31:2] == WA_HEX_HI);
    assign sel_lcd    = (addr[31:2] == WA_LCD);
    assign sel_sw     = (addr[31:2] == WA_SW);
    assign sel_btn    = (addr[31:2] == WA_BTN);

    // Access size classification and effective lane offset / misalign detection
    always_comb begin
        st_word  = |bmask[3:2];
        st_half  = bmask[1] & ~st_word;
        ld_word  = (ld_sel == 3'b010);
        ld_half  = (ld_sel == 3'b001) || (ld_sel == 3'b100);
        ld_valid = (ld_sel <= 3'b100);
`ifdef LSU_MISALIGN_CHK_EN
        st_off = addr[1:0];
        ld_off = addr[1:0];
        mis    = (wr_en    & ((st_half & addr[0]) | (st_word & (|addr[1:0])))) |
                 (ld_valid & ((ld_half & addr[0]) | (ld_word & (|addr[1:0]))));
`else
        // Half accesses keep only addr[1], word accesses ignore the low bits
        st_off = st_word ? 2'b00 : (st_half ? {addr[1], 1'b0} : addr[1:0]);
        ld_off = ld_word ? 2'b00 : (ld_half ? {addr[1], 1'b0} : addr[1:0]);
        mis    = 1'b0;
`endif
    end

    assign misalign = mis;
    assign do_store = wr_en & ~mis;
    assign st_lanes = bmask << st_off;
    assign st_wdata = st_data << {st_off, 3'b000};

    // Data memory write; contents deliberately survive reset, but no write
    // may land while reset is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
        end else if (do_store && sel_dmem) begin
            for (int i = 0; i < 4; i++) begin
                if (st_lanes[i]) dmem[widx][8*i +: 8] <= st_wdata[8*i +: 8];
            end
        end
    end

    // Output registers with per-lane store enables
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ledr   <= '0;
            ledg   <= '0;
            hex_lo <= '0;
            hex_hi <= '0;
            lcd    <= '0;
        end else if (do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (st_lanes[i]) begin
                    if (sel_ledr)   ledr[8*i +: 8]   <= st_wdata[8*i +: 8];
                    if (sel_ledg)   ledg[8*i +: 8]   <= st_wdata[8*i +: 8];
                    if (sel_hex_lo) hex_lo[8*i +: 8] <= st_wdata[8*i +: 8];
                    if (sel_hex_hi) hex_hi[8*i +: 8] <= st_wdata[8*i +: 8];
                    if (sel_lcd)    lcd[8*i +: 8]    <= st_wdata[8*i +: 8];
                end
            end
        end
    end

    // Input synchronisers for the asynchronous switch and button pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sw_sync[i]  <= '0;
                btn_sync[i] <= '0;
            end
        end else begin
            sw_sync[0]  <= io_sw;
            btn_sync[0] <= io_btn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sw_sync[i]  <= sw_sync[i-1];
                btn_sync[i] <= btn_sync[i-1];
            end
        end
    end

    // Read word select by address decode
    always_comb begin
        rword  = '0;
        mapped = 1'b1;
        if (sel_dmem)        rword = dmem[widx];
        else if (sel_ledr)   rword = ledr;
        else if (sel_ledg)   rword = ledg;
        else if (sel_hex_lo) rword = hex_lo;
        else if (sel_hex_hi) rword = hex_hi;
        else if (sel_lcd)    rword = lcd;
        else if (sel_sw)     rword = sw_sync[SYNC_STAGES-1];
        else if (sel_btn)    rword = {28'h0, btn_sync[SYNC_STAGES-1]};
        else                 mapped = 1'b0;
    end

    assign rshift = rword >> {ld_off, 3'b000};

    // Lane extraction and sign/zero extension of the load result
    always_comb begin
        ld_data = '0;
        if (mapped && !mis) begin
            case (ld_sel)
                3'b000:  ld_data = {{24{rshift[7]}}, rshift[7:0]};
                3'b001:  ld_data = {{16{rshift[15]}}, rshift[15:0]};
                3'b010:  ld_data = rshift;
                3'b011:  ld_data = {24'h0, rshift[7:0]};
                3'b100:  ld_data = {16'h0, rshift[15:0]};
                default: ld_data = '0;
            endcase
        end
    end

    assign io_ledr = ledr;
    assign io_ledg = ledg;
    assign io_lcd  = lcd;

    // Seven-segment digits: bits [6:0] of each register byte
    always_comb begin
        io_hex = '0;
        for (int n = 0; n < 4; n++) begin
            io_hex[7*n +: 7]       = hex_lo[8*n +: 7];
            io_hex[7*(n+4) +: 7]   = hex_hi[8*n +: 7];
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu.
// Follows LSU_MISALIGN_CHK_EN the same way the design does.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr, st_data, ld_data, io_sw, io_ledr, io_ledg, io_lcd;
    logic        wr_en, misalign;
    logic [3:0]  bmask, io_btn;
    logic [2:0]  ld_sel;
    logic [55:0] io_hex;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010,
                           LBU = 3'b011, LHU = 3'b100, NOLD = 3'b111;

    lsu #(.DMEM_AW(13), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .st_data(st_data),
        .wr_en(wr_en), .bmask(bmask), .ld_sel(ld_sel), .ld_data(ld_data),
        .misalign(misalign), .io_sw(io_sw), .io_btn(io_btn),
        .io_ledr(io_ledr), .io_ledg(io_ledg), .io_hex(io_hex), .io_lcd(io_lcd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        addr = a; st_data = d; bmask = m; wr_en = 1'b1; ld_sel = NOLD;
        step();
        wr_en = 1'b0;
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] sel);
        addr = a; ld_sel = sel; wr_en = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; addr = '0; st_data = '0; wr_en = 1'b0; bmask = '0;
        ld_sel = NOLD; io_sw = 32'h0000_005A; io_btn = 4'h0;
        step(); step(); step();
        rst_n = 1'b1;
        check("rst_ledr", 64'(io_ledr), 64'h0);
        check("rst_ledg", 64'(io_ledg), 64'h0);
        check("rst_lcd",  64'(io_lcd),  64'h0);
        check("rst_hex",  64'(io_hex),  64'h0);
        load(32'h1000_0000, LW);
        check("rst_ld_ledr", 64'(ld_data), 64'h0);

        // Load extension on a stored word
        store(32'h0000_0100, 32'hDEAD_BEEF, 4'b1111);
        load(32'h0000_0101, LB);  check("lb_101",  64'(ld_data), 64'hFFFF_FFBE);
        load(32'h0000_0101, LBU); check("lbu_101", 64'(ld_data), 64'h0000_00BE);
        load(32'h0000_0102, LH);  check("lh_102",  64'(ld_data), 64'hFFFF_DEAD);
        load(32'h0000_0100, LHU); check("lhu_100", 64'(ld_data), 64'h0000_BEEF);
        load(32'h0000_0100, LW);  check("lw_100",  64'(ld_data), 64'hDEAD_BEEF);

        // Partial stores merge into one word
        store(32'h0000_0200, 32'h1122_3344, 4'b1111);
        store(32'h0000_0203, 32'h0000_00AA, 4'b0001);
        store(32'h0000_0200, 32'h0000_5566, 4'b0011);
        load(32'h0000_0200, LW);  check("lw_200_merge", 64'(ld_data), 64'hAA22_5566);

        // Top DMEM word and the first address past it
        store(32'h0000_1FFC, 32'h0BAD_F00D, 4'b1111);
        load(32'h0000_1FFC, LW);  check("lw_dmem_top", 64'(ld_data), 64'h0BAD_F00D);
        load(32'h0000_2000, LW);  check("lw_past_dmem", 64'(ld_data), 64'h0);

        // Seven-segment registers
        store(32'h1000_2000, 32'h0000_007F, 4'b1111);
        check("hex_lo_7f", 64'(io_hex), 64'h7F);
        store(32'h1000_3000, 32'h1234_5678, 4'b1111);
        check("hex_hi", 64'(io_hex), 64'({7'h12, 7'h34, 7'h56, 7'h78, 28'h000_007F}));
        load(32'h1000_3000, LW);  check("ld_hex_hi", 64'(ld_data), 64'h1234_5678);

        // LED / LCD registers and byte/half lanes into them
        store(32'h1000_0000, 32'hCAFE_F00D, 4'b1111);
        store(32'h1000_0002, 32'h0000_0099, 4'b0001);
        check("ledr_sb", 64'(io_ledr), 64'hCA99_F00D);
        store(32'h1000_1002, 32'h0000_BEEF, 4'b0011);
        check("ledg_sh", 64'(io_ledg), 64'hBEEF_0000);
        store(32'h1000_4000, 32'h0000_0155, 4'b1111);
        check("lcd_sw", 64'(io_lcd), 64'h0000_0155);
        load(32'h1000_0002, LHU); check("lhu_ledr", 64'(ld_data), 64'h0000_CA99);
        load(32'h1000_0002, LH);  check("lh_ledr",  64'(ld_data), 64'hFFFF_CA99);

        // Switch synchroniser: old value for one edge, new after two
        load(32'h1001_0000, LW);  check("sw_settled", 64'(ld_data), 64'h0000_005A);
        store(32'h1001_0000, 32'hFFFF_FFFF, 4'b1111);
        load(32'h1001_0000, LW);  check("sw_store_ignored", 64'(ld_data), 64'h0000_005A);
        io_sw = 32'h0000_00A5;
        load(32'h1001_0000, LW);  check("sw_edge0", 64'(ld_data), 64'h0000_005A);
        step();
        check("sw_edge1", 64'(ld_data), 64'h0000_005A);
        step();
        check("sw_edge2", 64'(ld_data), 64'h0000_00A5);
        io_btn = 4'hB;
        step(); step();
        load(32'h1001_1000, LW);  check("btn", 64'(ld_data), 64'h0000_000B);

        // Unmapped addresses and non-load selects
        store(32'h2000_0000, 32'h1234_5678, 4'b1111);
        load(32'h2000_0000, LW);  check("unmapped", 64'(ld_data), 64'h0);
        load(32'h1000_0004, LW);  check("ledr_plus4", 64'(ld_data), 64'h0);
        load(32'h0000_0100, NOLD); check("ld_none", 64'(ld_data), 64'h0);
        load(32'h0000_0100, 3'b101); check("ld_rsvd", 64'(ld_data), 64'h0);

        // Store and load of one address in the same cycle
        addr = 32'h0000_0100; st_data = 32'h0102_0304; bmask = 4'b1111;
        wr_en = 1'b1; ld_sel = LW;
        #1;
        check("raw_old", 64'(ld_data), 64'hDEAD_BEEF);
        step();
        wr_en = 1'b0;
        #1;
        check("raw_new", 64'(ld_data), 64'h0102_0304);

        // Misaligned accesses
        addr = 32'h0000_0102; st_data = 32'hFFFF_FFFF; bmask = 4'b1111;
        wr_en = 1'b1; ld_sel = NOLD;
        #1;
`ifdef LSU_MISALIGN_CHK_EN
        check("mis_sw_flag", 64'(misalign), 64'h1);
        step();
        wr_en = 1'b0;
        load(32'h0000_0100, LW);  check("mis_sw_drop", 64'(ld_data), 64'h0102_0304);
        load(32'h0000_0101, LH);
        check("mis_lh_flag", 64'(misalign), 64'h1);
        check("mis_lh_data", 64'(ld_data), 64'h0);
        load(32'h0000_0101, LB);
        check("lb_no_flag", 64'(misalign), 64'h0);
        check("lb_101_b", 64'(ld_data), 64'h0000_0003);
`else
        check("mis_sw_flag", 64'(misalign), 64'h0);
        step();
        wr_en = 1'b0;
        load(32'h0000_0100, LW);  check("mis_sw_aligned", 64'(ld_data), 64'hFFFF_FFFF);
        store(32'h0000_0103, 32'h0000_8001, 4'b0011);
        load(32'h0000_0100, LW);  check("mis_sh_aligned", 64'(ld_data), 64'h8001_FFFF);
        load(32'h0000_0103, LHU);
        check("mis_lhu_flag", 64'(misalign), 64'h0);
        check("mis_lhu_data", 64'(ld_data), 64'h0000_8001);
`endif

        // Reset mid-program: registers clear at once, DMEM store dropped
        store(32'h0000_0300, 32'h1234_5678, 4'b1111);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ledr", 64'(io_ledr), 64'h0);
        check("async_rst_hex",  64'(io_hex),  64'h0);
        addr = 32'h0000_0300; st_data = 32'hFFFF_FFFF; bmask = 4'b1111;
        wr_en = 1'b1; ld_sel = NOLD;
        step(); step();
        wr_en = 1'b0;
        rst_n = 1'b1;
        load(32'h1001_0000, LW);  check("sw_sync_rst", 64'(ld_data), 64'h0);
        load(32'h0000_0300, LW);  check("rst_store_drop", 64'(ld_data), 64'h1234_5678);
        store(32'h1000_0000, 32'h0000_0001, 4'b1111);
        check("post_rst_store", 64'(io_ledr), 64'h0000_0001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load-store unit directly downstream of the decoder in the single-cycle RV32I core.
- Consumes the decoder's `wr_en`, `bmask` and `ld_sel` together with the ALU address and the rs2 data.
- Holds the data memory and the memory-mapped I/O registers (LEDs, 7-seg, LCD, switches, buttons).
- Returns sign- or zero-extended load data to the write-back mux.

Parameters:
DMEM_AW, 13, byte-address width of data memory (2^13 = 8 KiB, word array of 2^(DMEM_AW-2) entries)
SYNC_STAGES, 2, flops in the input synchroniser for io_sw/io_btn (legal range 2-3)

Ports:
clk  in  1  core clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
addr  in  32  byte address from ALU
st_data  in  32  rs2 data, right-aligned
wr_en  in  1  store enable from decoder
bmask  in  4  store byte mask, unshifted (sb 0001, sh 0011, sw 1111)
ld_sel  in  3  000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu, 111 no load
ld_data  out  32  extended load result, combinational
misalign  out  1  current access is misaligned (see Optional Feature)
io_sw  in  32  switches, asynchronous to clk
io_btn  in  4  push buttons, asynchronous to clk
io_ledr  out  32  red LED register
io_ledg  out  32  green LED register
io_hex  out  56  8 digits x 7 segments; digit n = register byte n bits[6:0]
io_lcd  out  32  LCD control register

Behaviour:
- Memory map (decode on full 32-bit addr):
  - 0x0000_0000 + [0, 2^DMEM_AW): DMEM
  - 0x1000_0000: LEDR
  - 0x1000_1000: LEDG
  - 0x1000_2000: HEX_LO (digits 0-3)
  - 0x1000_3000: HEX_HI (digits 4-7)
  - 0x1000_4000: LCD
  - 0x1001_0000: SW (read-only)
  - 0x1001_1000: BTN (read-only, bits[3:0], upper bits read 0)
  - Each I/O register decodes its 4-byte word only.
  - All other addresses are unmapped.
- Store:
  - When wr_en=1, byte lanes = bmask << addr[1:0].
  - Write data = st_data << (8*addr[1:0]).
  - Written at the rising edge into the selected DMEM word or output register; only enabled lanes change.
- Store to SW/BTN or an unmapped address: no state change.
- Load: read is combinational, same cycle (zero latency).
  - Word is selected by addr[31:2]; lane is shifted down by addr[1:0].
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend.
- ld_sel=111, reserved ld_sel codes, or an unmapped address: ld_data = 0.
- Load of an output register returns its current value; SW/BTN return the synchroniser output.
- Store and load to the same address in one cycle: ld_data shows the old value; the new value is visible from the next cycle.
- Inputs: io_sw and io_btn pass through SYNC_STAGES flops each.
  - A change on a pin is visible in ld_data exactly SYNC_STAGES clk edges later.
- Reset (rst_n=0, asynchronous):
  - LEDR, LEDG, HEX_LO, HEX_HI, LCD and all synchroniser flops go to 0, so io_ledr/io_ledg/io_hex/io_lcd = 0.
  - DMEM is not reset; contents are undefined until written.
  - A store presented while rst_n=0 is dropped.
  - Reset deasserting mid-program: the next edge with wr_en=1 writes normally.
- Outputs are driven directly from registers; no combinational path from addr to io_* outputs.

Optional Feature:
- Macro: LSU_MISALIGN_CHK_EN.
- Defined:
  - A misaligned access is lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=00.
  - On a misaligned access, misalign=1 combinationally.
  - The store is suppressed and ld_data=0.
  - Byte accesses never flag.
- Not defined:
  - misalign is tied 0.
  - Effective lane offset is forced aligned: half accesses use addr[1] only; word accesses ignore addr[1:0].
  - The access then completes as an aligned access.

Test Plan:
- Reset then release: io_ledr=io_ledg=io_lcd=0, io_hex=0; a load of 0x1000_0000 returns 0x0000_0000.
- sw 0xDEAD_BEEF to 0x100, then:
  - lb 0x101 -> 0xFFFF_FFBE
  - lbu 0x101 -> 0x0000_00BE
  - lh 0x102 -> 0xFFFF_DEAD
  - lhu 0x100 -> 0x0000_BEEF
- sw 0x1122_3344 to 0x200, then sb 0xAA to 0x203 and sh 0x5566 to 0x200: lw 0x200 -> 0xAA22_5566.
- sw 0x0000_007F to 0x1000_2000: io_hex[6:0]=0x7F, others 0. sw to 0x1001_0000 leaves the SW readback unchanged.
- io_sw steps to 0x0000_00A5 at an edge: loads of 0x1001_0000 return the old value for SYNC_STAGES-1 edges, then 0x0000_00A5. A load of 0x2000_0000 returns 0.
- With LSU_MISALIGN_CHK_EN: sw 0xFFFF_FFFF to 0x102 -> misalign=1, word 0x100 unchanged. Without the macro: the same store writes 0xFFFF_FFFF to 0x100 and misalign=0.
